// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, byte-lane masks
// and the store steering / alignment helpers used by the top level.
package mem_access_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } state_e;

    // Reserved size 3 falls through to word everywhere.
    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            SIZE_B:  m = MASK_BYTE << addr_lo;
            SIZE_H:  m = MASK_HALF << {addr_lo[1], 1'b0};
            default: m = MASK_WORD;
        endcase
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] store_data(input logic [1:0] size, input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] d;
        case (size)
            SIZE_B:  d = {4{wdata[7:0]}};
            SIZE_H:  d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Core-side request/response bus and data-memory port bundles for mem_access_unit.
interface mem_access_core_if;
    import mem_access_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface mem_access_mem_if;
    import mem_access_pkg::*;

    logic              mem_valid;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [3:0]        mem_write_mask;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_valid, mem_write_enable, mem_write_addr, mem_write_data, mem_write_mask, mem_read_addr,
        input  mem_read_data
    );

    modport slave (
        input  mem_valid, mem_write_enable, mem_write_addr, mem_write_data, mem_write_mask, mem_read_addr,
        output mem_read_data
    );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load-data lane select and sign/zero extension of a 32-bit RAM word.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = data_i[7:0];
            2'd1: byte_sel = data_i[15:8];
            2'd2: byte_sel = data_i[23:16];
            2'd3: byte_sel = data_i[31:24];
            default: byte_sel = data_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
    end

    always_comb begin
        data_o = data_i;
        case (size_i)
            SIZE_B: data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            SIZE_H: data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator: IDLE -> ISSUE -> CAPTURE -> RESP.
// Optional misaligned-access trap enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    mem_access_core_if.slave core,
    mem_access_mem_if.master mem
);

    state_e            state_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              mem_valid_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_mask_q;
    logic              wen_q;
    logic [1:0]        size_q;
    logic [1:0]        addr_lo_q;
    logic              unsigned_q;
    logic [DATA_W-1:0] load_data;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic resp_err_q;
    logic trap_req;
    assign trap_req = is_misaligned(core.req_size, core.req_addr[1:0]);
`endif

    mem_load_align u_align (
        .data_i    (mem.mem_read_data),
        .addr_lo_i (addr_lo_q),
        .size_i    (size_q),
        .unsigned_i(unsigned_q),
        .data_o    (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_mask_q   <= MASK_NONE;
            wen_q        <= 1'b0;
            size_q       <= SIZE_B;
            addr_lo_q    <= 2'b00;
            unsigned_q   <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (core.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        wen_q       <= core.req_wen;
                        size_q      <= core.req_size;
                        addr_lo_q   <= core.req_addr[1:0];
                        unsigned_q  <= core.req_unsigned;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                        if (trap_req) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else
`endif
                        begin
                            state_q     <= ST_ISSUE;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= core.req_wen;
                            mem_addr_q  <= {core.req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= core.req_wen ? store_data(core.req_size, core.req_wdata) : '0;
                            mem_mask_q  <= core.req_wen ? store_mask(core.req_size, core.req_addr[1:0])
                                                        : MASK_NONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q     <= ST_CAPTURE;
                    mem_valid_q <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_mask_q  <= MASK_NONE;
                end
                ST_CAPTURE: begin
                    // RAM read data is valid this cycle, one cycle after the access edge.
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= wen_q ? '0 : load_data;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    resp_err_q   <= 1'b0;
`endif
                end
                ST_RESP: begin
                    if (core.resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Reset masks the memory port combinationally so an in-flight ISSUE can never write.
    assign core.req_ready       = req_ready_q & ~reset;
    assign core.resp_valid      = resp_valid_q;
    assign core.resp_rdata      = resp_rdata_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign core.resp_err        = resp_err_q;
`else
    assign core.resp_err        = 1'b0;
`endif
    assign mem.mem_valid        = mem_valid_q & ~reset;
    assign mem.mem_write_enable = mem_we_q & ~reset;
    assign mem.mem_write_addr   = reset ? '0 : mem_addr_q;
    assign mem.mem_read_addr    = reset ? '0 : mem_addr_q;
    assign mem.mem_write_data   = reset ? '0 : mem_wdata_q;
    assign mem.mem_write_mask   = reset ? MASK_NONE : mem_mask_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a one-cycle registered-read RAM model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_core_if core_bus();
    mem_access_mem_if  mem_bus();

    mem_access_unit dut (
        .clock(clk),
        .reset(rst),
        .core (core_bus),
        .mem  (mem_bus)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] mem_word = 32'h0;
    int unsigned pulse_cnt = 0;

    // RAM model: read data only meaningful the cycle after a read access.
    always @(posedge clk) begin
        mem_bus.mem_read_data <= (mem_bus.mem_valid && !mem_bus.mem_write_enable) ? mem_word : 32'hDEAD_DEAD;
        if (mem_bus.mem_valid) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns);
        core_bus.req_wen      = wen;
        core_bus.req_addr     = addr;
        core_bus.req_wdata    = wdata;
        core_bus.req_size     = size;
        core_bus.req_unsigned = uns;
        core_bus.req_valid    = 1'b1;
        tick();
        core_bus.req_valid    = 1'b0;
        $display("txn %s addr=%h wdata=%h size=%0d unsigned=%0d", wen ? "store" : "load ",
                 addr, wdata, size, uns);
    endtask

    task automatic test_reset();
        core_bus.req_valid = 1'b0; core_bus.req_wen = 1'b0; core_bus.req_addr = '0;
        core_bus.req_wdata = '0;   core_bus.req_size = SIZE_B; core_bus.req_unsigned = 1'b0;
        core_bus.resp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        n_vec++; if (core_bus.req_ready !== 1'b0) begin n_miss++; $display("FAIL rst_req_ready: got %b want 0", core_bus.req_ready); end
        n_vec++; if (core_bus.resp_valid !== 1'b0) begin n_miss++; $display("FAIL rst_resp_valid: got %b want 0", core_bus.resp_valid); end
        n_vec++; if (core_bus.resp_rdata !== 32'h0) begin n_miss++; $display("FAIL rst_resp_rdata: got %h want 0", core_bus.resp_rdata); end
        n_vec++; if (core_bus.resp_err !== 1'b0) begin n_miss++; $display("FAIL rst_resp_err: got %b want 0", core_bus.resp_err); end
        n_vec++; if (mem_bus.mem_valid !== 1'b0) begin n_miss++; $display("FAIL rst_mem_valid: got %b want 0", mem_bus.mem_valid); end
        n_vec++; if ({mem_bus.mem_write_addr, mem_bus.mem_write_mask} !== 36'h0) begin n_miss++; $display("FAIL rst_mem_bus: got %h/%b want 0", mem_bus.mem_write_addr, mem_bus.mem_write_mask); end
        rst = 1'b0;
        #1;
        n_vec++; if (core_bus.req_ready !== 1'b1) begin n_miss++; $display("FAIL post_rst_req_ready: got %b want 1", core_bus.req_ready); end
        $display("txn reset released");
    endtask

    task automatic test_store();
        logic [31:0] t_addr [5] = '{32'h8000_0003, 32'h8000_0002, 32'h8000_0010, 32'h8000_0004, 32'h8000_0001};
        logic [31:0] t_wd   [5] = '{32'h0000_00AB, 32'h1234_CAFE, 32'h1234_CAFE, 32'hDEAD_BEEF, 32'h0000_0055};
        logic [1:0]  t_sz   [5] = '{SIZE_B, SIZE_H, SIZE_H, SIZE_W, SIZE_B};
        logic [31:0] e_data [5] = '{32'hABAB_ABAB, 32'hCAFE_CAFE, 32'hCAFE_CAFE, 32'hDEAD_BEEF, 32'h5555_5555};
        logic [3:0]  e_mask [5] = '{4'b1000, 4'b1100, 4'b0011, 4'b1111, 4'b0010};
        logic [31:0] e_addr [5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0010, 32'h8000_0004, 32'h8000_0000};
        int unsigned base;
        for (int i = 0; i < 5; i++) begin
            base = pulse_cnt;
            do_req(1'b1, t_addr[i], t_wd[i], t_sz[i], 1'b0);
            n_vec++; if ({mem_bus.mem_valid, mem_bus.mem_write_enable} !== 2'b11) begin n_miss++; $display("FAIL st_issue[%0d]: valid/we got %b%b want 11", i, mem_bus.mem_valid, mem_bus.mem_write_enable); end
            n_vec++; if (mem_bus.mem_write_addr !== e_addr[i]) begin n_miss++; $display("FAIL st_waddr[%0d]: got %h want %h", i, mem_bus.mem_write_addr, e_addr[i]); end
            n_vec++; if (mem_bus.mem_write_data !== e_data[i]) begin n_miss++; $display("FAIL st_wdata[%0d]: got %h want %h", i, mem_bus.mem_write_data, e_data[i]); end
            n_vec++; if (mem_bus.mem_write_mask !== e_mask[i]) begin n_miss++; $display("FAIL st_mask[%0d]: got %b want %b", i, mem_bus.mem_write_mask, e_mask[i]); end
            tick();
            n_vec++; if ({mem_bus.mem_valid, core_bus.resp_valid} !== 2'b00) begin n_miss++; $display("FAIL st_capture[%0d]: mem_valid/resp_valid got %b%b want 00", i, mem_bus.mem_valid, core_bus.resp_valid); end
            tick();
            n_vec++; if ({core_bus.resp_valid, core_bus.resp_rdata} !== {1'b1, 32'h0}) begin n_miss++; $display("FAIL st_resp[%0d]: valid=%b rdata=%h want 1/0", i, core_bus.resp_valid, core_bus.resp_rdata); end
            n_vec++; if (pulse_cnt - base !== 1) begin n_miss++; $display("FAIL st_pulses[%0d]: got %0d want 1", i, pulse_cnt - base); end
            tick();
            n_vec++; if ({core_bus.resp_valid, core_bus.req_ready} !== 2'b01) begin n_miss++; $display("FAIL st_done[%0d]: resp_valid/req_ready got %b%b want 01", i, core_bus.resp_valid, core_bus.req_ready); end
        end
    endtask

    task automatic test_load();
        logic [31:0] t_word [9] = '{32'h0080_1234, 32'h0080_1234, 32'h0080_1234, 32'h0080_1234, 32'hBEEF_0000,
                                    32'hBEEF_0000, 32'h1234_7FFF, 32'h89AB_CDEF, 32'hF000_0000};
        logic [31:0] t_addr [9] = '{32'h8000_0002, 32'h8000_0002, 32'h8000_0000, 32'h8000_0001, 32'h8000_0002,
                                    32'h8000_0002, 32'h8000_0000, 32'h8000_0008, 32'h8000_0003};
        logic [1:0]  t_sz   [9] = '{SIZE_B, SIZE_B, SIZE_B, SIZE_B, SIZE_H, SIZE_H, SIZE_H, SIZE_W, SIZE_B};
        logic        t_uns  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] e_data [9] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0034, 32'h0000_0012, 32'h0000_BEEF,
                                    32'hFFFF_BEEF, 32'h0000_7FFF, 32'h89AB_CDEF, 32'h0000_00F0};
        logic [31:0] e_addr;
        for (int i = 0; i < 9; i++) begin
            mem_word = t_word[i];
            e_addr = {t_addr[i][31:2], 2'b00};
            do_req(1'b0, t_addr[i], 32'hFFFF_FFFF, t_sz[i], t_uns[i]);
            n_vec++; if ({mem_bus.mem_valid, mem_bus.mem_write_enable, mem_bus.mem_write_mask} !== 6'b10_0000) begin n_miss++; $display("FAIL ld_issue[%0d]: valid/we/mask got %b%b%b want 1/0/0000", i, mem_bus.mem_valid, mem_bus.mem_write_enable, mem_bus.mem_write_mask); end
            n_vec++; if (mem_bus.mem_read_addr !== e_addr) begin n_miss++; $display("FAIL ld_raddr[%0d]: got %h want %h", i, mem_bus.mem_read_addr, e_addr); end
            tick();
            tick();
            n_vec++; if (core_bus.resp_valid !== 1'b1) begin n_miss++; $display("FAIL ld_resp_valid[%0d]: got %b want 1", i, core_bus.resp_valid); end
            n_vec++; if (core_bus.resp_rdata !== e_data[i]) begin n_miss++; $display("FAIL ld_rdata[%0d]: got %h want %h", i, core_bus.resp_rdata, e_data[i]); end
            tick();
        end
    endtask

    task automatic test_stall();
        int unsigned base;
        mem_word = 32'h0080_1234;
        core_bus.resp_ready = 1'b0;
        base = pulse_cnt;
        do_req(1'b0, 32'h8000_0002, 32'h0, SIZE_B, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_vec++; if ({core_bus.resp_valid, core_bus.req_ready} !== 2'b10) begin n_miss++; $display("FAIL stall_hs[%0d]: resp_valid/req_ready got %b%b want 10", i, core_bus.resp_valid, core_bus.req_ready); end
            n_vec++; if (core_bus.resp_rdata !== 32'hFFFF_FF80) begin n_miss++; $display("FAIL stall_rdata[%0d]: got %h want ffffff80", i, core_bus.resp_rdata); end
            n_vec++; if (pulse_cnt - base !== 1) begin n_miss++; $display("FAIL stall_pulses[%0d]: got %0d want 1", i, pulse_cnt - base); end
            tick();
        end
        core_bus.resp_ready = 1'b1;
        tick();
        n_vec++; if ({core_bus.resp_valid, core_bus.req_ready} !== 2'b01) begin n_miss++; $display("FAIL stall_release: resp_valid/req_ready got %b%b want 01", core_bus.resp_valid, core_bus.req_ready); end
    endtask

    task automatic test_back_to_back();
        int unsigned base;
        mem_word = 32'h1122_3344;
        base = pulse_cnt;
        do_req(1'b0, 32'h8000_0020, 32'h0, SIZE_W, 1'b0);
        tick();
        tick();
        n_vec++; if (core_bus.req_ready !== 1'b0) begin n_miss++; $display("FAIL b2b_busy: req_ready got %b want 0", core_bus.req_ready); end
        tick();
        n_vec++; if (core_bus.req_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_ready_n4: req_ready got %b want 1", core_bus.req_ready); end
        do_req(1'b0, 32'h8000_0021, 32'h0, SIZE_B, 1'b1);
        n_vec++; if ({mem_bus.mem_valid, mem_bus.mem_read_addr} !== {1'b1, 32'h8000_0020}) begin n_miss++; $display("FAIL b2b_issue2: valid=%b raddr=%h want 1/80000020", mem_bus.mem_valid, mem_bus.mem_read_addr); end
        tick();
        tick();
        n_vec++; if (core_bus.resp_rdata !== 32'h0000_0033) begin n_miss++; $display("FAIL b2b_rdata2: got %h want 00000033", core_bus.resp_rdata); end
        n_vec++; if (pulse_cnt - base !== 2) begin n_miss++; $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt - base); end
        tick();
    endtask

    task automatic test_reset_mid();
        int unsigned base;
        base = pulse_cnt;
        do_req(1'b1, 32'h8000_0004, 32'hA5A5_5A5A, SIZE_W, 1'b0);
        rst = 1'b1;
        #1;
        n_vec++; if ({mem_bus.mem_valid, mem_bus.mem_write_enable} !== 2'b00) begin n_miss++; $display("FAIL rmid_gate: valid/we got %b%b want 00", mem_bus.mem_valid, mem_bus.mem_write_enable); end
        tick();
        n_vec++; if ({core_bus.req_ready, core_bus.resp_valid, mem_bus.mem_valid, mem_bus.mem_write_mask} !== 7'b0) begin n_miss++; $display("FAIL rmid_outputs: ready/rv/mv/mask got %b%b%b%b want all 0", core_bus.req_ready, core_bus.resp_valid, mem_bus.mem_valid, mem_bus.mem_write_mask); end
        n_vec++; if (mem_bus.mem_write_addr !== 32'h0) begin n_miss++; $display("FAIL rmid_waddr: got %h want 0", mem_bus.mem_write_addr); end
        rst = 1'b0;
        #1;
        n_vec++; if (core_bus.req_ready !== 1'b1) begin n_miss++; $display("FAIL rmid_idle: req_ready got %b want 1", core_bus.req_ready); end
        repeat (3) tick();
        n_vec++; if ({core_bus.resp_valid, mem_bus.mem_valid} !== 2'b00) begin n_miss++; $display("FAIL rmid_dropped: resp_valid/mem_valid got %b%b want 00", core_bus.resp_valid, mem_bus.mem_valid); end
        n_vec++; if (pulse_cnt - base !== 0) begin n_miss++; $display("FAIL rmid_pulses: got %0d want 0", pulse_cnt - base); end
        $display("txn reset during issue released");
    endtask

    task automatic test_misalign();
        int unsigned base;
        mem_word = 32'hCAFE_F00D;
        base = pulse_cnt;
        do_req(1'b0, 32'h8000_0002, 32'h0, SIZE_W, 1'b0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        n_vec++; if ({core_bus.resp_valid, core_bus.resp_err} !== 2'b11) begin n_miss++; $display("FAIL mis_trap: resp_valid/resp_err got %b%b want 11", core_bus.resp_valid, core_bus.resp_err); end
        n_vec++; if (core_bus.resp_rdata !== 32'h0) begin n_miss++; $display("FAIL mis_rdata: got %h want 0", core_bus.resp_rdata); end
        n_vec++; if (mem_bus.mem_valid !== 1'b0) begin n_miss++; $display("FAIL mis_mem_valid: got %b want 0", mem_bus.mem_valid); end
        tick();
        n_vec++; if ({core_bus.resp_valid, core_bus.req_ready} !== 2'b01) begin n_miss++; $display("FAIL mis_done: resp_valid/req_ready got %b%b want 01", core_bus.resp_valid, core_bus.req_ready); end
        n_vec++; if (pulse_cnt - base !== 0) begin n_miss++; $display("FAIL mis_pulses: got %0d want 0", pulse_cnt - base); end
`else
        n_vec++; if ({mem_bus.mem_valid, mem_bus.mem_read_addr} !== {1'b1, 32'h8000_0000}) begin n_miss++; $display("FAIL mis_issue: valid=%b raddr=%h want 1/80000000", mem_bus.mem_valid, mem_bus.mem_read_addr); end
        tick();
        tick();
        n_vec++; if ({core_bus.resp_valid, core_bus.resp_err} !== 2'b10) begin n_miss++; $display("FAIL mis_resp: resp_valid/resp_err got %b%b want 10", core_bus.resp_valid, core_bus.resp_err); end
        n_vec++; if (core_bus.resp_rdata !== 32'hCAFE_F00D) begin n_miss++; $display("FAIL mis_rdata: got %h want cafef00d", core_bus.resp_rdata); end
        tick();
        n_vec++; if (pulse_cnt - base !== 1) begin n_miss++; $display("FAIL mis_pulses: got %0d want 1", pulse_cnt - base); end
`endif
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
